// File: rtl/chip_bus_pkg.sv
// ============================================================================
// Module      : chip_bus_pkg
// Description : Shared types, default widths and parity helper for the
//               chip_bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chip_bus_pkg;

    localparam int CHIP_BUS_ADDR_W  = 8;
    localparam int CHIP_BUS_DATA_W  = 32;
    // Widest vector the parity helper accepts; callers zero-extend.
    localparam int PARITY_MAX_W     = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Even parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chip_bus_ram.sv
// ============================================================================
// Module      : chip_bus_ram
// Description : Single-port synchronous storage, DEPTH x DATA_W, with write
//               enable and registered read data. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip_bus_ram #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // One access per enabled edge: write the word, or register the read word.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/chip_bus_mem_responder.sv
// ============================================================================
// Module      : chip_bus_mem_responder
// Description : Responder end of the chip_bus cache protocol. Accepts one
//               read/write request at a time, waits WAIT_STATES cycles, then
//               presents a response held until rsp_ready.
//               Optional request/response parity: define CHIP_BUS_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip_bus_mem_responder
    import chip_bus_pkg::*;
#(
    parameter int ADDR_W      = CHIP_BUS_ADDR_W,
    parameter int DATA_W      = CHIP_BUS_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef CHIP_BUS_PARITY_EN
    input  logic              req_parity,
    output logic              rsp_parity,
`endif
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              rsp_ready
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(WAIT_STATES - 1);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               resp_err;
    logic               resp_write;

    logic               accept;
    logic               commit;
    logic               live_bad;
    logic               c_write;
    logic [RAM_AW-1:0]  c_addr;
    logic [DATA_W-1:0]  c_wdata;
    logic               c_bad;
    logic [DATA_W-1:0]  ram_rdata;

    assign req_ready = (state == ST_IDLE) && !reset;
    assign accept    = (state == ST_IDLE) && req;

`ifdef CHIP_BUS_PARITY_EN
    assign live_bad = ({1'b0, req_addr} >= DEPTH_LIMIT) ||
                      (req_parity != even_parity(PARITY_MAX_W'({req_write, req_addr, req_wdata})));
`else
    assign live_bad = ({1'b0, req_addr} >= DEPTH_LIMIT);
`endif

    // Commit happens on the edge that enters RESP: straight from IDLE with
    // no wait states (live inputs), otherwise from WAIT (latched request).
    generate
        if (WAIT_STATES == 0) begin : g_no_wait
            assign commit  = accept;
            assign c_write = req_write;
            assign c_addr  = req_addr[RAM_AW-1:0];
            assign c_wdata = req_wdata;
            assign c_bad   = live_bad;
        end else begin : g_wait
            logic              lat_write;
            logic [RAM_AW-1:0] lat_addr;
            logic [DATA_W-1:0] lat_wdata;
            logic              lat_bad;

            // Capture the request at acceptance; inputs are ignored afterwards.
            always_ff @(posedge clock) begin
                if (reset) begin
                    lat_write <= 1'b0;
                    lat_addr  <= '0;
                    lat_wdata <= '0;
                    lat_bad   <= 1'b0;
                end else if (accept) begin
                    lat_write <= req_write;
                    lat_addr  <= req_addr[RAM_AW-1:0];
                    lat_wdata <= req_wdata;
                    lat_bad   <= live_bad;
                end
            end

            assign commit  = (state == ST_WAIT) && (wait_cnt == '0);
            assign c_write = lat_write;
            assign c_addr  = lat_addr;
            assign c_wdata = lat_wdata;
            assign c_bad   = lat_bad;
        end
    endgenerate

    chip_bus_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clock  (clock),
        .en     (commit && !c_bad && !reset),
        .we     (c_write),
        .addr   (c_addr),
        .wdata  (c_wdata),
        .rdata  (ram_rdata)
    );

    // Request/response sequencing and wait-state counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            resp_err   <= 1'b0;
            resp_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (commit) begin
                resp_err   <= c_bad;
                resp_write <= c_write;
            end
        end
    end

    // Response fields are only meaningful in RESP; read data only for good reads.
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid && resp_err;
    assign rsp_rdata = (rsp_valid && !resp_err && !resp_write) ? ram_rdata : '0;

`ifdef CHIP_BUS_PARITY_EN
    assign rsp_parity = even_parity(PARITY_MAX_W'({rsp_err, rsp_rdata}));
`endif

endmodule

`default_nettype wire

// File: tb/tb_chip_bus_mem_responder.sv
// ============================================================================
// Module      : tb_chip_bus_mem_responder
// Description : Directed self-checking bench. Instance A uses WAIT_STATES=2,
//               instance B uses WAIT_STATES=0; they share request inputs and
//               are selected by holding the idle one in reset.
//               Parity checks are built when CHIP_BUS_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chip_bus_mem_responder;

    logic        clock = 1'b0;
    logic        reset_a, reset_b;
    logic        req, req_write, req_parity, rsp_ready;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;

    logic        a_ready, a_valid, a_err, a_parity;
    logic [31:0] a_rdata;
    logic        b_ready, b_valid, b_err, b_parity;
    logic [31:0] b_rdata;

    logic        sel;
    logic        cur_ready, cur_valid, cur_err, cur_parity;
    logic [31:0] cur_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    chip_bus_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_STATES(2)) dut_a (
        .clock(clock), .reset(reset_a), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef CHIP_BUS_PARITY_EN
        .req_parity(req_parity), .rsp_parity(a_parity),
`endif
        .req_ready(a_ready), .rsp_valid(a_valid), .rsp_rdata(a_rdata),
        .rsp_err(a_err), .rsp_ready(rsp_ready)
    );

    chip_bus_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_STATES(0)) dut_b (
        .clock(clock), .reset(reset_b), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef CHIP_BUS_PARITY_EN
        .req_parity(req_parity), .rsp_parity(b_parity),
`endif
        .req_ready(b_ready), .rsp_valid(b_valid), .rsp_rdata(b_rdata),
        .rsp_err(b_err), .rsp_ready(rsp_ready)
    );

`ifndef CHIP_BUS_PARITY_EN
    assign a_parity = 1'b0;
    assign b_parity = 1'b0;
`endif

    assign cur_ready  = sel ? b_ready  : a_ready;
    assign cur_valid  = sel ? b_valid  : a_valid;
    assign cur_err    = sel ? b_err    : a_err;
    assign cur_rdata  = sel ? b_rdata  : a_rdata;
    assign cur_parity = sel ? b_parity : a_parity;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one request (called #1 after a rising edge with the DUT idle),
    // measure cycles to rsp_valid, capture the response, let it handshake.
    task automatic txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic flip, output int lat, output logic [31:0] rd,
                       output logic er, output logic rp);
        check("accept_ready", {31'd0, cur_ready}, 32'd1);
        req        = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_parity = (^{w, a, d}) ^ flip;
        @(posedge clock); #1;
        req = 1'b0;
        lat = 0; rd = '0; er = 1'b0; rp = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (cur_valid) begin
                lat = i; rd = cur_rdata; er = cur_err; rp = cur_parity;
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          lat;
        int          seen;
        logic [31:0] rd;
        logic        er, rp;

        sel = 1'b0; reset_a = 1'b1; reset_b = 1'b1;
        req = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_parity = 1'b0; rsp_ready = 1'b1;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clock);
            check("rst_ready", {31'd0, a_ready}, 32'd0);
            check("rst_valid", {31'd0, a_valid}, 32'd0);
        end
        @(posedge clock); #1 reset_a = 1'b0;
        @(negedge clock);
        check("post_rst_ready", {31'd0, a_ready}, 32'd1);
        check("post_rst_rdata", a_rdata, 32'd0);
        check("post_rst_err",   {31'd0, a_err}, 32'd0);
        @(posedge clock); #1;

        // Write then read, WAIT_STATES=2
        txn(1'b1, 8'h05, 32'hDEADBEEF, 1'b0, lat, rd, er, rp);
        check("wr_latency", lat, 32'd3);
        check("wr_err",     {31'd0, er}, 32'd0);
        check("wr_rdata",   rd, 32'd0);
        check("wr_idle_ready", {31'd0, cur_ready}, 32'd1);
        check("wr_idle_valid", {31'd0, cur_valid}, 32'd0);
        txn(1'b0, 8'h05, 32'h0, 1'b0, lat, rd, er, rp);
        check("rd_latency", lat, 32'd3);
        check("rd_rdata",   rd, 32'hDEADBEEF);
        check("rd_err",     {31'd0, er}, 32'd0);

        // Backpressure, with a stray write presented while busy
        rsp_ready = 1'b0;
        req = 1'b1; req_write = 1'b0; req_addr = 8'h05; req_wdata = '0;
        @(posedge clock); #1;
        req_write = 1'b1; req_wdata = 32'hBAD0BAD0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (a_valid) begin lat = i; break; end
        end
        check("bp_latency", lat, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", {31'd0, a_valid}, 32'd1);
            check("bp_rdata", a_rdata, 32'hDEADBEEF);
            check("bp_ready", {31'd0, a_ready}, 32'd0);
        end
        @(posedge clock); #1 rsp_ready = 1'b1;
        @(negedge clock);
        check("hs_valid", {31'd0, a_valid}, 32'd1);
        check("hs_ready", {31'd0, a_ready}, 32'd0);
        @(posedge clock); #1 req = 1'b0;
        check("after_hs_valid", {31'd0, a_valid}, 32'd0);
        check("after_hs_ready", {31'd0, a_ready}, 32'd1);
        txn(1'b0, 8'h05, 32'h0, 1'b0, lat, rd, er, rp);
        check("stray_not_written", rd, 32'hDEADBEEF);

        // Out of range write leaves storage untouched
        txn(1'b1, 8'h00, 32'h0000A5A5, 1'b0, lat, rd, er, rp);
        check("wr0_err", {31'd0, er}, 32'd0);
        txn(1'b1, 8'h40, 32'hFFFFFFFF, 1'b0, lat, rd, er, rp);
        check("oor_err",     {31'd0, er}, 32'd1);
        check("oor_rdata",   rd, 32'd0);
        check("oor_latency", lat, 32'd3);
        txn(1'b0, 8'h00, 32'h0, 1'b0, lat, rd, er, rp);
        check("rd0_rdata", rd, 32'h0000A5A5);
        check("rd0_err",   {31'd0, er}, 32'd0);

        // Reset during WAIT aborts the write
        txn(1'b1, 8'h01, 32'h00001111, 1'b0, lat, rd, er, rp);
        req = 1'b1; req_write = 1'b1; req_addr = 8'h01; req_wdata = 32'h00001234;
        @(posedge clock); #1 req = 1'b0;
        @(negedge clock);
        check("mid_wait_valid", {31'd0, a_valid}, 32'd0);
        @(posedge clock); #1 reset_a = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (a_valid) seen++;
        end
        check("abort_no_rsp", seen, 32'd0);
        @(posedge clock); #1;
        txn(1'b0, 8'h01, 32'h0, 1'b0, lat, rd, er, rp);
        check("abort_old_data", rd, 32'h00001111);

        // WAIT_STATES=0 instance
        sel = 1'b1;
        reset_a = 1'b1;
        @(posedge clock); #1 reset_b = 1'b0;
        @(negedge clock);
        check("b_post_rst_ready", {31'd0, b_ready}, 32'd1);
        @(posedge clock); #1;
        txn(1'b1, 8'h02, 32'h00000077, 1'b0, lat, rd, er, rp);
        check("b_wr_latency", lat, 32'd1);
        check("b_wr_err", {31'd0, er}, 32'd0);
        txn(1'b0, 8'h02, 32'h0, 1'b0, lat, rd, er, rp);
        check("b_rd_latency", lat, 32'd1);
        check("b_rd_rdata", rd, 32'h00000077);
        txn(1'b1, 8'h3F, 32'h0, 1'b0, lat, rd, er, rp);
        check("b_last_addr_err", {31'd0, er}, 32'd0);

`ifdef CHIP_BUS_PARITY_EN
        check("b_rd_parity", {31'd0, rp}, 32'd0);
        txn(1'b1, 8'h03, 32'h00000005, 1'b0, lat, rd, er, rp);
        check("par_good_err", {31'd0, er}, 32'd0);
        txn(1'b1, 8'h03, 32'h00000009, 1'b1, lat, rd, er, rp);
        check("par_bad_err",    {31'd0, er}, 32'd1);
        check("par_bad_rdata",  rd, 32'd0);
        check("par_bad_parity", {31'd0, rp}, 32'd1);
        txn(1'b0, 8'h03, 32'h0, 1'b0, lat, rd, er, rp);
        check("par_rd_rdata",  rd, 32'h00000005);
        check("par_rd_parity", {31'd0, rp}, 32'd0);
        txn(1'b0, 8'h07, 32'h0, 1'b0, lat, rd, er, rp);
        txn(1'b0, 8'h02, 32'h0, 1'b0, lat, rd, er, rp);
        check("par_rd2_parity", {31'd0, rp}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
